// File: rtl/gate_op_arbiter_if.sv
// Requester/gate-unit/result bundle for gate_op_arbiter.
// slave = arbiter side, master = environment (requesters, gate unit, result consumer).
`timescale 1ns/1ps
interface gate_op_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned ID_W  = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] op_in;
  logic [W*N_REQ-1:0] a_in;
  logic [W*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [2:0]         gate_op;
  logic [W-1:0]       gate_a;
  logic [W-1:0]       gate_b;
  logic [W-1:0]       gate_o;
  logic               res_valid;
  logic [ID_W-1:0]    res_id;
  logic [W-1:0]       res_data;
  logic               res_ready;

  modport slave (
    input  req, op_in, a_in, b_in, gate_o, res_ready,
    output gnt, gate_op, gate_a, gate_b, res_valid, res_id, res_data
  );

  modport master (
    output req, op_in, a_in, b_in, gate_o, res_ready,
    input  gnt, gate_op, gate_a, gate_b, res_valid, res_id, res_data
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one combinational 2-input gate unit among N_REQ requesters;
// issues registered operands, captures the result and returns it tagged with the requester id.
`timescale 1ns/1ps
module gate_op_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned ID_W  = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_op_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       gate_op_q, gate_op_d;
  logic [W-1:0]     gate_a_q, gate_a_d;
  logic [W-1:0]     gate_b_q, gate_b_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [W-1:0]     res_data_q, res_data_d;

  logic             sel_found_c;
  logic [ID_W-1:0]  sel_idx_c;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!sel_found_c && bus.req[idx]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    gate_op_d   = gate_op_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      IDLE: begin
        if (sel_found_c) begin
          gnt_d     = N_REQ'(1) << sel_idx_c;
          gate_op_d = bus.op_in[3*32'(sel_idx_c) +: 3];
          gate_a_d  = bus.a_in[W*32'(sel_idx_c) +: W];
          gate_b_d  = bus.b_in[W*32'(sel_idx_c) +: W];
          res_id_d  = sel_idx_c;
          state_d   = EVAL;
        end
      end
      // gate_* settled through the whole cycle; sample the unit's output.
      EVAL: begin
        res_data_d  = bus.gate_o;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = ID_W'((32'(res_id_q) + 32'd1) % N_REQ);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      gate_op_q   <= '0;
      gate_a_q    <= '0;
      gate_b_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      gate_op_q   <= gate_op_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gate_op   = gate_op_q;
  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter (N_REQ=4, W=1) with a behavioural gate unit.
`timescale 1ns/1ps
module tb_gate_op_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned W     = 1;
  localparam int unsigned ID_W  = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  int   cyc;

  gate_op_arbiter_if #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) bus ();

  gate_op_arbiter #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External gate unit.
  always_comb begin
    case (bus.gate_op)
      3'd0:    bus.gate_o = bus.gate_a & bus.gate_b;
      3'd1:    bus.gate_o = bus.gate_a | bus.gate_b;
      3'd2:    bus.gate_o = bus.gate_a ^ bus.gate_b;
      3'd3:    bus.gate_o = ~(bus.gate_a & bus.gate_b);
      3'd4:    bus.gate_o = ~(bus.gate_a | bus.gate_b);
      3'd5:    bus.gate_o = ~(bus.gate_a ^ bus.gate_b);
      3'd6:    bus.gate_o = ~bus.gate_a;
      default: bus.gate_o = bus.gate_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic a, input logic b);
    bus.op_in[3*i +: 3] = op;
    bus.a_in[i]         = a;
    bus.b_in[i]         = b;
  endtask

  task automatic wait_gnt(input int budget, output logic [N_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        g = bus.gnt;
        return;
      end
    end
    chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Truth tables indexed by {a,b}: bit3=11, bit2=10, bit1=01, bit0=00.
  logic [3:0] tt [8];
  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [N_REQ-1:0] g;
    int               last;
    int               exp_order [5];
    logic [3:0]       row;
    exp_order = '{0, 1, 2, 3, 0};
    n_chk = 0; n_bad = 0; cyc = 0; last = 0;
    rst_n = 1'b0;
    bus.req = '0; bus.op_in = '0; bus.a_in = '0; bus.b_in = '0; bus.res_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_gnt",   32'(bus.gnt),       0);
    chk("rst_op",    32'(bus.gate_op),   0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_id",    32'(bus.res_id),    0);
    chk("rst_data",  32'(bus.res_data),  0);
    rst_n = 1'b1;

    // Single XOR op from requester 0
    @(negedge clk);
    set_req(0, 3'd2, 1'b1, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(5, g);
    chk("single_gnt",   32'(g),              1);
    chk("single_op",    32'(bus.gate_op),    2);
    chk("single_a",     32'(bus.gate_a),     1);
    chk("single_b",     32'(bus.gate_b),     0);
    chk("single_nv",    32'(bus.res_valid),  0);
    bus.req = '0;
    @(negedge clk);
    chk("single_gnt_off", 32'(bus.gnt),      0);
    chk("single_valid", 32'(bus.res_valid),  1);
    chk("single_id",    32'(bus.res_id),     0);
    chk("single_data",  32'(bus.res_data),   1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("single_acc",   32'(bus.res_valid),  0);
    bus.res_ready = 1'b0;

    // Async reset while in EVAL
    set_req(0, 3'd1, 1'b1, 1'b1);
    bus.req = 4'b0001;
    wait_gnt(5, g);
    chk("mid_pre_gnt", 32'(g), 1);
    bus.req = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_gnt",   32'(bus.gnt),       0);
    chk("mid_op",    32'(bus.gate_op),   0);
    chk("mid_a",     32'(bus.gate_a),    0);
    chk("mid_b",     32'(bus.gate_b),    0);
    chk("mid_valid", 32'(bus.res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_gnt",   32'(bus.gnt),       0);
      chk("post_rst_valid", 32'(bus.res_valid), 0);
    end

    // Round-robin with all four requesting
    for (int i = 0; i < 4; i++) set_req(i, 3'd0, 1'b1, 1'b1);
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(10, g);
      chk("rr_gnt", 32'(g), 32'(1 << exp_order[k]));
      if (k > 0) chk("rr_spacing", 32'(cyc - last), 3);
      last = cyc;
      if (k == 4) bus.req = '0;
      @(negedge clk);
      chk("rr_valid", 32'(bus.res_valid), 1);
      chk("rr_id",    32'(bus.res_id),    32'(exp_order[k]));
      chk("rr_data",  32'(bus.res_data),  1);
    end
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Backpressure with requester 1 pending
    set_req(0, 3'd1, 1'b0, 1'b1);
    bus.req = 4'b0001;
    wait_gnt(5, g);
    chk("bp_gnt0", 32'(g), 1);
    bus.req = '0;
    @(negedge clk);
    set_req(1, 3'd0, 1'b1, 1'b0);
    bus.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_id",    32'(bus.res_id),    0);
      chk("bp_data",  32'(bus.res_data),  1);
      chk("bp_gnt",   32'(bus.gnt),       0);
      chk("bp_gop",   32'(bus.gate_op),   1);
      chk("bp_ga",    32'(bus.gate_a),    0);
      chk("bp_gb",    32'(bus.gate_b),    1);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_acc", 32'(bus.res_valid), 0);
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("bp_gnt1",  32'(bus.gnt),     2);
    chk("bp_gop1",  32'(bus.gate_op), 0);

    // Late/dropped requests: req[3] only in EVAL, req[1] raised in RESP
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = '0;
    chk("late_valid", 32'(bus.res_valid), 1);
    chk("late_id",    32'(bus.res_id),    1);
    chk("late_data",  32'(bus.res_data),  0);
    chk("late_gnt",   32'(bus.gnt),       0);
    set_req(1, 3'd7, 1'b1, 1'b0);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("late_resp_gnt", 32'(bus.gnt), 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("late_acc",     32'(bus.res_valid), 0);
    chk("late_acc_gnt", 32'(bus.gnt),       0);
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("late_gnt1", 32'(bus.gnt),     2);
    chk("late_gop",  32'(bus.gate_op), 7);
    bus.req = '0;
    @(negedge clk);
    chk("late_buf", 32'(bus.res_data), 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Opcode sweep on requester 2
    for (int op = 0; op < 8; op++) begin
      row = tt[op];
      for (int ab = 0; ab < 4; ab++) begin
        set_req(2, 3'(op), ab[1], ab[0]);
        bus.req = 4'b0100;
        wait_gnt(5, g);
        chk("sw_gnt", 32'(g), 4);
        bus.req = '0;
        @(negedge clk);
        chk("sw_valid", 32'(bus.res_valid), 1);
        chk("sw_id",    32'(bus.res_id),    2);
        chk($sformatf("sw_op%0d_ab%0d", op, ab), 32'(bus.res_data), 32'(row[ab]));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
